// File: rtl/fu_completion_scheduler_pkg.sv
// Shared types and constants for the FU completion scheduler: FU state encoding,
// bus widths and the completion record broadcast on the wakeup ports.
package fu_completion_scheduler_pkg;

  localparam int NUM_FU  = 3;
  localparam int NUM_CDB = 2;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_BUSY = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] val;
  } comp_rec_t;

  // Folds a round-robin scan position (rr_ptr + offset, at most 4) back into 0..2.
  function automatic logic [1:0] rr_wrap(input logic [2:0] pos);
    logic [2:0] tmp;
    tmp = (pos >= 3'd3) ? (pos - 3'd3) : pos;
    return tmp[1:0];
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
  endfunction

endpackage

// File: rtl/fu_completion_scheduler_if.sv
// Reservation-station side bundle: issue requests, FU datapath results, ready
// flags and the two wakeup broadcast ports.
interface fu_completion_scheduler_if;
  import fu_completion_scheduler_pkg::*;

  logic              issue_FU1_valid;
  logic              issue_FU2_valid;
  logic              issue_FU3_valid;
  logic              issue_0_is_LS;
  logic              issue_1_is_LS;
  logic              issue_2_is_LS;
  logic [TAG_W-1:0]  issue_0_rd_tag;
  logic [TAG_W-1:0]  issue_1_rd_tag;
  logic [TAG_W-1:0]  issue_2_rd_tag;
  logic [TAG_W-1:0]  issue_0_rob_num;
  logic [TAG_W-1:0]  issue_1_rob_num;
  logic [TAG_W-1:0]  issue_2_rob_num;
  logic [DATA_W-1:0] fu0_result;
  logic [DATA_W-1:0] fu1_result;
  logic [DATA_W-1:0] fu2_result;

  logic              FU1_ready;
  logic              FU2_ready;
  logic              FU3_ready;
  logic              wakeup_1_valid;
  logic              wakeup_2_valid;
  logic [TAG_W-1:0]  wakeup_1_tag;
  logic [TAG_W-1:0]  wakeup_2_tag;
  logic [DATA_W-1:0] wakeup_1_val;
  logic [DATA_W-1:0] wakeup_2_val;
  logic [TAG_W-1:0]  wakeup_1_rob;
  logic [TAG_W-1:0]  wakeup_2_rob;
  logic              protocol_err;

  modport master (
    output issue_FU1_valid, issue_FU2_valid, issue_FU3_valid,
    output issue_0_is_LS, issue_1_is_LS, issue_2_is_LS,
    output issue_0_rd_tag, issue_1_rd_tag, issue_2_rd_tag,
    output issue_0_rob_num, issue_1_rob_num, issue_2_rob_num,
    output fu0_result, fu1_result, fu2_result,
    input  FU1_ready, FU2_ready, FU3_ready,
    input  wakeup_1_valid, wakeup_2_valid,
    input  wakeup_1_tag, wakeup_2_tag,
    input  wakeup_1_val, wakeup_2_val,
    input  wakeup_1_rob, wakeup_2_rob,
    input  protocol_err
  );

  modport slave (
    input  issue_FU1_valid, issue_FU2_valid, issue_FU3_valid,
    input  issue_0_is_LS, issue_1_is_LS, issue_2_is_LS,
    input  issue_0_rd_tag, issue_1_rd_tag, issue_2_rd_tag,
    input  issue_0_rob_num, issue_1_rob_num, issue_2_rob_num,
    input  fu0_result, fu1_result, fu2_result,
    output FU1_ready, FU2_ready, FU3_ready,
    output wakeup_1_valid, wakeup_2_valid,
    output wakeup_1_tag, wakeup_2_tag,
    output wakeup_1_val, wakeup_2_val,
    output wakeup_1_rob, wakeup_2_rob,
    output protocol_err
  );

endinterface

// File: rtl/fu_completion_scheduler_fu_lat_tracker.sv
// One functional unit's occupancy tracker: IDLE/BUSY/DONE state machine, latency
// countdown and the holding register for its completed result.
module fu_lat_tracker
  import fu_completion_scheduler_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int LS_LAT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_ls,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [TAG_W-1:0]  issue_rob,
  input  logic [DATA_W-1:0] fu_result,
  input  logic              grant,
  output logic              ready,
  output logic              req,
  output logic              issue_err,
  output comp_rec_t         rec
);

  localparam int MAX_LAT = (LS_LAT > ALU_LAT) ? LS_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] ALU_INIT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] LS_INIT  = CNT_W'(LS_LAT - 1);

  fu_state_e        state_q;
  fu_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  comp_rec_t        rec_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FU_IDLE: if (issue_valid)     state_d = FU_BUSY;
      FU_BUSY: if (cnt_q == '0)     state_d = FU_DONE;
      FU_DONE: if (grant)           state_d = FU_IDLE;
      default:                      state_d = FU_IDLE;
    endcase
  end

  // cnt_q counts the edges still to go before the capture edge, so the result
  // is sampled exactly LAT edges after the issue edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      rec_q <= '0;
    end else begin
      case (state_q)
        FU_IDLE: begin
          if (issue_valid) begin
            cnt_q     <= issue_is_ls ? LS_INIT : ALU_INIT;
            rec_q.tag <= issue_tag;
            rec_q.rob <= issue_rob;
          end
        end
        FU_BUSY: begin
          if (cnt_q == '0) rec_q.val <= fu_result;
          else             cnt_q     <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready     = (state_q == FU_IDLE);
    req       = (state_q == FU_DONE);
    issue_err = issue_valid && (state_q != FU_IDLE);
    rec       = rec_q;
  end

endmodule

// File: rtl/fu_completion_scheduler.sv
// Tracks three functional units and broadcasts their completed results on two
// wakeup ports using a rotating-priority arbiter.
module fu_completion_scheduler
  import fu_completion_scheduler_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int LS_LAT  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  fu_completion_scheduler_if.slave  bus
);

  logic [NUM_FU-1:0]  issue_valid;
  logic [NUM_FU-1:0]  issue_is_ls;
  logic [TAG_W-1:0]   issue_tag    [NUM_FU];
  logic [TAG_W-1:0]   issue_rob    [NUM_FU];
  logic [DATA_W-1:0]  fu_result    [NUM_FU];
  logic [NUM_FU-1:0]  ready;
  logic [NUM_FU-1:0]  req;
  logic [NUM_FU-1:0]  grant;
  logic [NUM_FU-1:0]  issue_err;
  comp_rec_t          rec          [NUM_FU];

  logic [1:0]         rr_q;
  logic [1:0]         rr_d;
  logic [NUM_CDB-1:0] port_valid;
  comp_rec_t          port_rec     [NUM_CDB];

  logic               wk1_valid_q;
  logic               wk2_valid_q;
  comp_rec_t          wk1_rec_q;
  comp_rec_t          wk2_rec_q;
  logic               proto_err_q;

  assign issue_valid  = {bus.issue_FU3_valid, bus.issue_FU2_valid, bus.issue_FU1_valid};
  assign issue_is_ls  = {bus.issue_2_is_LS, bus.issue_1_is_LS, bus.issue_0_is_LS};
  assign issue_tag[0] = bus.issue_0_rd_tag;
  assign issue_tag[1] = bus.issue_1_rd_tag;
  assign issue_tag[2] = bus.issue_2_rd_tag;
  assign issue_rob[0] = bus.issue_0_rob_num;
  assign issue_rob[1] = bus.issue_1_rob_num;
  assign issue_rob[2] = bus.issue_2_rob_num;
  assign fu_result[0] = bus.fu0_result;
  assign fu_result[1] = bus.fu1_result;
  assign fu_result[2] = bus.fu2_result;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    fu_lat_tracker #(
      .ALU_LAT (ALU_LAT),
      .LS_LAT  (LS_LAT)
    ) u_trk (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid[g]),
      .issue_is_ls (issue_is_ls[g]),
      .issue_tag   (issue_tag[g]),
      .issue_rob   (issue_rob[g]),
      .fu_result   (fu_result[g]),
      .grant       (grant[g]),
      .ready       (ready[g]),
      .req         (req[g]),
      .issue_err   (issue_err[g]),
      .rec         (rec[g])
    );
  end

  // Scan DONE units starting at rr_q; the first two found take ports 1 and 2,
  // and the pointer moves just past the last unit served.
  always_comb begin
    logic [1:0] idx;
    grant       = '0;
    port_valid  = '0;
    port_rec[0] = '0;
    port_rec[1] = '0;
    rr_d        = rr_q;
    idx         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = rr_wrap({1'b0, rr_q} + 3'(k));
      if (req[idx]) begin
        if (!port_valid[0]) begin
          port_valid[0] = 1'b1;
          port_rec[0]   = rec[idx];
          grant[idx]    = 1'b1;
          rr_d          = rr_next(idx);
        end else if (!port_valid[1]) begin
          port_valid[1] = 1'b1;
          port_rec[1]   = rec[idx];
          grant[idx]    = 1'b1;
          rr_d          = rr_next(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Idle ports drop valid but keep their last payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      wk1_valid_q <= 1'b0;
      wk2_valid_q <= 1'b0;
      wk1_rec_q   <= '0;
      wk2_rec_q   <= '0;
    end else begin
      wk1_valid_q <= port_valid[0];
      wk2_valid_q <= port_valid[1];
      if (port_valid[0]) wk1_rec_q <= port_rec[0];
      if (port_valid[1]) wk2_rec_q <= port_rec[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           proto_err_q <= 1'b0;
    else if (|issue_err) proto_err_q <= 1'b1;
  end

  assign bus.FU1_ready      = ready[0];
  assign bus.FU2_ready      = ready[1];
  assign bus.FU3_ready      = ready[2];
  assign bus.wakeup_1_valid = wk1_valid_q;
  assign bus.wakeup_2_valid = wk2_valid_q;
  assign bus.wakeup_1_tag   = wk1_rec_q.tag;
  assign bus.wakeup_2_tag   = wk2_rec_q.tag;
  assign bus.wakeup_1_val   = wk1_rec_q.val;
  assign bus.wakeup_2_val   = wk2_rec_q.val;
  assign bus.wakeup_1_rob   = wk1_rec_q.rob;
  assign bus.wakeup_2_rob   = wk2_rec_q.rob;
  assign bus.protocol_err   = proto_err_q;

endmodule

// File: tb/tb_fu_completion_scheduler.sv
// Self-checking bench for fu_completion_scheduler: directed timing checks plus a
// tag-indexed scoreboard that every wakeup broadcast is matched against.
module tb_fu_completion_scheduler;
  import fu_completion_scheduler_pkg::*;

  localparam int ALU_LAT = 1;
  localparam int LS_LAT  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fu_completion_scheduler_if bus();

  fu_completion_scheduler #(
    .ALU_LAT (ALU_LAT),
    .LS_LAT  (LS_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] val;
    int                issue_edge;
    int                base_lat;
  } sb_t;

  sb_t exp_q[$];
  int  total = 0;
  int  passed = 0;
  int  cyc = 0;
  int  grants[NUM_FU];
  bit  fair_window = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic clearIssues();
    bus.issue_FU1_valid = 1'b0;
    bus.issue_FU2_valid = 1'b0;
    bus.issue_FU3_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clearIssues();
    @(negedge clk);
  endtask

  // Called on a falling edge; the issue takes effect at the following rising edge.
  task automatic applyStimulus(input int fu, input bit is_ls, input logic [TAG_W-1:0] tag,
                               input logic [TAG_W-1:0] rob, input logic [DATA_W-1:0] val,
                               input bit expect_it);
    sb_t e;
    case (fu)
      0: begin
        bus.issue_FU1_valid = 1'b1; bus.issue_0_is_LS = is_ls;
        bus.issue_0_rd_tag = tag;   bus.issue_0_rob_num = rob;
        if (expect_it) bus.fu0_result = val;
      end
      1: begin
        bus.issue_FU2_valid = 1'b1; bus.issue_1_is_LS = is_ls;
        bus.issue_1_rd_tag = tag;   bus.issue_1_rob_num = rob;
        if (expect_it) bus.fu1_result = val;
      end
      default: begin
        bus.issue_FU3_valid = 1'b1; bus.issue_2_is_LS = is_ls;
        bus.issue_2_rd_tag = tag;   bus.issue_2_rob_num = rob;
        if (expect_it) bus.fu2_result = val;
      end
    endcase
    if (expect_it) begin
      e.tag = tag; e.rob = rob; e.val = val;
      e.issue_edge = cyc + 1;
      e.base_lat = (is_ls ? LS_LAT : ALU_LAT) + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkWakeup(input int port, input logic [TAG_W-1:0] tag,
                             input logic [TAG_W-1:0] rob, input logic [DATA_W-1:0] val);
    int hit;
    int lat;
    hit = -1;
    foreach (exp_q[j]) if (hit < 0 && exp_q[j].tag == tag) hit = j;
    checkOutput($sformatf("wk%0d_known_tag_%0h", port, tag), 64'(hit >= 0), 64'd1);
    if (hit >= 0) begin
      lat = cyc - exp_q[hit].issue_edge;
      checkOutput($sformatf("wk%0d_rob", port), 64'(rob), 64'(exp_q[hit].rob));
      checkOutput($sformatf("wk%0d_val", port), 64'(val), 64'(exp_q[hit].val));
      checkOutput($sformatf("wk%0d_latency_%0d", port, lat),
                  64'(lat >= exp_q[hit].base_lat && lat <= exp_q[hit].base_lat + 1), 64'd1);
      if (fair_window && int'(tag[5:4]) < NUM_FU) grants[int'(tag[5:4])]++;
      exp_q.delete(hit);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wakeup_1_valid === 1'b1) checkWakeup(1, bus.wakeup_1_tag, bus.wakeup_1_rob, bus.wakeup_1_val);
    if (bus.wakeup_2_valid === 1'b1) checkWakeup(2, bus.wakeup_2_tag, bus.wakeup_2_rob, bus.wakeup_2_val);
    if (bus.wakeup_1_valid === 1'b1 && bus.wakeup_2_valid === 1'b1)
      checkOutput("wk_distinct_tags", 64'(bus.wakeup_1_tag != bus.wakeup_2_tag), 64'd1);
  end

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  logic [2:0] ready3;
  assign ready3 = {bus.FU3_ready, bus.FU2_ready, bus.FU1_ready};

  initial begin
    int seq;
    int gmin;
    int gmax;
    logic [TAG_W-1:0] t;
    reset = 1'b1;
    clearIssues();
    bus.issue_0_is_LS = 1'b0; bus.issue_1_is_LS = 1'b0; bus.issue_2_is_LS = 1'b0;
    bus.issue_0_rd_tag = '0;  bus.issue_1_rd_tag = '0;  bus.issue_2_rd_tag = '0;
    bus.issue_0_rob_num = '0; bus.issue_1_rob_num = '0; bus.issue_2_rob_num = '0;
    bus.fu0_result = '0;      bus.fu1_result = '0;      bus.fu2_result = '0;
    foreach (grants[i]) grants[i] = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("idle_state", {ready3, bus.wakeup_1_valid, bus.wakeup_2_valid, bus.protocol_err}, 6'b111_000);
    end

    // Single ALU op on FU1.
    applyStimulus(0, 1'b0, 6'd5, 6'd2, 32'h1234, 1'b1);
    step();
    checkOutput("t2_fu1_busy", bus.FU1_ready, 1'b0);
    step();
    checkOutput("t2_no_early_wk", bus.wakeup_1_valid, 1'b0);
    step();
    checkOutput("t2_wk1", {bus.wakeup_1_valid, bus.wakeup_1_tag, bus.wakeup_1_rob, bus.wakeup_1_val},
                {1'b1, 6'd5, 6'd2, 32'h1234});
    checkOutput("t2_wk2_idle", bus.wakeup_2_valid, 1'b0);
    checkOutput("t2_fu1_ready", bus.FU1_ready, 1'b1);
    step();
    checkOutput("t2_wk1_one_cycle", bus.wakeup_1_valid, 1'b0);
    checkOutput("t2_wk1_tag_held", bus.wakeup_1_tag, 6'd5);

    // LS op on FU2 plus an illegal second issue while it is busy.
    applyStimulus(1, 1'b1, 6'd9, 6'd3, 32'hBEEF, 1'b1);
    step();
    applyStimulus(1, 1'b0, 6'd10, 6'd4, 32'h0, 1'b0);
    step();
    checkOutput("t3_perr", bus.protocol_err, 1'b1);
    checkOutput("t3_fu2_busy", bus.FU2_ready, 1'b0);
    step();
    step();
    checkOutput("t3_no_early_wk", bus.wakeup_1_valid, 1'b0);
    step();
    checkOutput("t3_wk1", {bus.wakeup_1_valid, bus.wakeup_1_tag, bus.wakeup_1_rob, bus.wakeup_1_val},
                {1'b1, 6'd9, 6'd3, 32'hBEEF});
    step();
    checkOutput("t3_perr_sticky", bus.protocol_err, 1'b1);
    doReset();
    checkOutput("t3_perr_cleared", bus.protocol_err, 1'b0);

    // All three FUs at once, twice, starting from rr_ptr = 0 each round.
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < NUM_FU; f++)
        applyStimulus(f, 1'b0, 6'(16 + r * 4 + f), 6'(40 + f), 32'hA000 + 32'(r * 16 + f), 1'b1);
      step();
      step();
      step();
      checkOutput("t4_port1_fu1", {bus.wakeup_1_valid, bus.wakeup_1_tag}, {1'b1, 6'(16 + r * 4)});
      checkOutput("t4_port2_fu2", {bus.wakeup_2_valid, bus.wakeup_2_tag}, {1'b1, 6'(17 + r * 4)});
      step();
      checkOutput("t4_port1_fu3", {bus.wakeup_1_valid, bus.wakeup_1_tag}, {1'b1, 6'(18 + r * 4)});
      checkOutput("t4_port2_idle", bus.wakeup_2_valid, 1'b0);
    end

    // Keep every FU busy and watch the grant spread.
    fair_window = 1'b1;
    seq = 0;
    for (int c = 0; c < 30; c++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (ready3[f]) begin
          t = {2'(f), 4'(seq)};
          applyStimulus(f, 1'b0, t, 6'(seq), $urandom, 1'b1);
          seq++;
        end
      end
      step();
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    fair_window = 1'b0;
    checkOutput("t5_drained", 64'(exp_q.size()), 64'd0);
    gmin = grants[0];
    gmax = grants[0];
    foreach (grants[i]) begin
      if (grants[i] < gmin) gmin = grants[i];
      if (grants[i] > gmax) gmax = grants[i];
    end
    checkOutput("t5_grant_spread", 64'(gmax - gmin <= 1), 64'd1);
    checkOutput("t5_all_served", 64'(gmin >= 5), 64'd1);
    checkOutput("t5_no_perr", bus.protocol_err, 1'b0);

    // Reset while FU3 holds a finished result and FU1 is still counting.
    applyStimulus(0, 1'b1, 6'h21, 6'd1, 32'h5555, 1'b1);
    applyStimulus(2, 1'b0, 6'h23, 6'd3, 32'h7777, 1'b1);
    step();
    step();
    checkOutput("t6_fu1_fu3_occupied", {bus.FU3_ready, bus.FU1_ready}, 2'b00);
    reset = 1'b1;
    exp_q.delete();
    step();
    checkOutput("t6_all_ready", ready3, 3'b111);
    checkOutput("t6_no_wakeup", {bus.wakeup_1_valid, bus.wakeup_2_valid}, 2'b00);
    checkOutput("t6_wk_cleared", {bus.wakeup_1_tag, bus.wakeup_1_rob, bus.wakeup_1_val}, 44'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("t6_quiet", {bus.wakeup_1_valid, bus.wakeup_2_valid}, 2'b00);
    end
    checkOutput("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
